// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: PC / pipeline-register enables for data-hazard stalls, memory freezes and branch flushes.
// Optional stall/freeze/flush performance counters are enabled with the PIPE_CTRL_PERF_EN macro.
module pipe_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_req,
  input  logic [1:0] stall_len,
  input  logic       branch_taken,
  input  logic       mem_busy,
  output logic       pc_wena,
  output logic       if_id_wena,
  output logic       if_id_flush,
  output logic       id_exe_bubble,
  output logic       exe_mem_wena,
  output logic       mem_wb_wena,
  output logic [1:0] state,
  output logic [1:0] remain
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] freeze_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_STALL  = 2'd1,
    S_HOLD   = 2'd2,
    S_UNUSED = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] remain_q, remain_d;
  logic [1:0] len_eff;

  // A zero-length request still costs one bubble.
  assign len_eff = (stall_len == 2'd0) ? 2'd1 : stall_len;

  always_comb begin
    state_d       = S_RUN;
    remain_d      = remain_q;
    pc_wena       = 1'b1;
    if_id_wena    = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    exe_mem_wena  = 1'b1;
    mem_wb_wena   = 1'b1;
    if (mem_busy) begin
      pc_wena      = 1'b0;
      if_id_wena   = 1'b0;
      exe_mem_wena = 1'b0;
      mem_wb_wena  = 1'b0;
      // An in-progress stall is parked, not cancelled, so no bubble is lost.
      state_d      = (state_q == S_STALL) ? S_STALL : S_HOLD;
    end else if (state_q == S_STALL) begin
      pc_wena       = 1'b0;
      if_id_wena    = 1'b0;
      id_exe_bubble = 1'b1;
      remain_d      = (remain_q == 2'd0) ? 2'd0 : remain_q - 2'd1;
      state_d       = (remain_q > 2'd1) ? S_STALL : S_RUN;
    end else if (stall_req) begin
      // Stall beats branch: ID re-presents the branch once the stall ends.
      pc_wena       = 1'b0;
      if_id_wena    = 1'b0;
      id_exe_bubble = 1'b1;
      if (len_eff > 2'd1) begin
        state_d  = S_STALL;
        remain_d = len_eff - 2'd1;
      end
    end else begin
      if_id_flush = branch_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      remain_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  assign state  = state_q;
  assign remain = remain_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] freeze_cnt_q, freeze_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (id_exe_bubble && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (mem_busy && (freeze_cnt_q != 32'hFFFF_FFFF))     freeze_cnt_d = freeze_cnt_q + 32'd1;
    if (if_id_flush && (flush_cnt_q != 32'hFFFF_FFFF))   flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= 32'd0;
      freeze_cnt_q <= 32'd0;
      flush_cnt_q  <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule
